max7219_display_ctrl: RTL and testbench

- Display back-end of the desk clock. Takes the current time as packed BCD hours/minutes/seconds.
- Encodes each digit to raw 7-segment patterns.
- Streams 16-bit register writes to a MAX7219 over a 3-wire serial link (dout/load/clk).
- After reset it sends the MAX7219 init sequence once, then refreshes all 8 digit registers continuously, one frame after another.

---
 rtl/max7219_display_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_max7219_display_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_display_ctrl.sv
// -----------------------------------------------------------------------------
// max7219_display_ctrl
//
// Display back-end of the desk clock. Sends the MAX7219 init sequence once
// after reset, then refreshes the eight digit registers continuously with the
// current time encoded as raw 7-segment patterns.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_en           enable; sampled only at word boundaries (GAP end, STALL)
//   i_hours        BCD hours   [7:4] tens, [3:0] units
//   i_minutes      BCD minutes
//   i_seconds      BCD seconds
//   o_serial_dout  serial data, MSB first, 0 outside SHIFT
//   o_serial_load  load/CS, high CLK_DIV cycles after the 16th bit
//   o_serial_clk   serial clock, CLK_DIV cycles low then CLK_DIV high per bit
//   o_init_done    high from the GAP of the last init word until reset
//   o_frame_stb    one-cycle pulse in the GAP of digit word 0x08
//
// Word cadence: 16 bits * 2*CLK_DIV + LOAD (CLK_DIV) + GAP (1) cycles.
// A frame adds one SNAP cycle in front of its first word.
// -----------------------------------------------------------------------------
module max7219_display_ctrl #(
   parameter int unsigned CLK_DIV    = 2,
   parameter logic [3:0]  INTENSITY  = 4'hA,
   parameter logic [2:0]  SCAN_LIMIT = 3'h7
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic [7:0] i_hours,
   input  logic [7:0] i_minutes,
   input  logic [7:0] i_seconds,
   output logic       o_serial_dout,
   output logic       o_serial_load,
   output logic       o_serial_clk,
   output logic       o_init_done,
   output logic       o_frame_stb
);

   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [2:0]     INIT_LAST = 3'd4;
   localparam logic [2:0]     DIG_LAST  = 3'd7;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_SNAP,
      ST_SHIFT,
      ST_LOAD,
      ST_GAP,
      ST_STALL
   } state_e;

   state_e           state_q,     state_d;
   logic [15:0]      word_q,      word_d;
   logic [3:0]       bit_cnt_q,   bit_cnt_d;
   logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
   logic             sclk_q,      sclk_d;
   logic [2:0]       idx_q,       idx_d;
   logic [2:0]       dig_q,       dig_d;
   logic             init_done_q, init_done_d;
   logic [7:0]       hours_q,     hours_d;
   logic [7:0]       minutes_q,   minutes_d;
   logic [7:0]       seconds_q,   seconds_d;

   // Raw segment pattern, bit7 = DP (unused), bits 6:0 = A..G.
   function automatic logic [7:0] seg7(input logic [3:0] nib);
      logic [7:0] pat;
      case (nib)
         4'd0:    pat = 8'h7E;
         4'd1:    pat = 8'h30;
         4'd2:    pat = 8'h6D;
         4'd3:    pat = 8'h79;
         4'd4:    pat = 8'h33;
         4'd5:    pat = 8'h5B;
         4'd6:    pat = 8'h5F;
         4'd7:    pat = 8'h70;
         4'd8:    pat = 8'h7F;
         4'd9:    pat = 8'h7B;
         default: pat = 8'h00;   // non-BCD nibble shows blank
      endcase
      return pat;
   endfunction

   function automatic logic [15:0] init_word(input logic [2:0] idx);
      logic [15:0] w;
      case (idx)
         3'd0:    w = 16'h0F00;
         3'd1:    w = 16'h0900;
         3'd2:    w = {8'h0A, 4'h0, INTENSITY};
         3'd3:    w = {8'h0B, 5'h00, SCAN_LIMIT};
         default: w = 16'h0C01;
      endcase
      return w;
   endfunction

   // Digit register dig+1 carries digit number dig; digits 6 and 7 are blank.
   function automatic logic [15:0] frame_word(input logic [2:0] dig,
                                              input logic [7:0] h,
                                              input logic [7:0] m,
                                              input logic [7:0] s);
      logic [3:0] nib;
      logic [7:0] data;
      case (dig)
         3'd0:    nib = h[7:4];
         3'd1:    nib = h[3:0];
         3'd2:    nib = m[7:4];
         3'd3:    nib = m[3:0];
         3'd4:    nib = s[7:4];
         3'd5:    nib = s[3:0];
         default: nib = 4'h0;
      endcase
      data = (dig >= 3'd6) ? 8'h00 : seg7(nib);
      return {4'h0, {1'b0, dig} + 4'd1, data};
   endfunction

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_INIT;
         word_q      <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         idx_q       <= '0;
         dig_q       <= '0;
         init_done_q <= 1'b0;
         hours_q     <= '0;
         minutes_q   <= '0;
         seconds_q   <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         sclk_q      <= sclk_d;
         idx_q       <= idx_d;
         dig_q       <= dig_d;
         init_done_q <= init_done_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seconds_q   <= seconds_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      sclk_d      = sclk_q;
      idx_d       = idx_q;
      dig_d       = dig_q;
      init_done_d = init_done_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      seconds_d   = seconds_q;

      case (state_q)
         ST_INIT: begin
            if (i_en) begin
               word_d    = init_word(idx_q);
               bit_cnt_d = '0;
               div_cnt_d = '0;
               sclk_d    = 1'b0;
               state_d   = ST_SHIFT;
            end else begin
               state_d = ST_STALL;
            end
         end

         ST_SNAP: begin
            // The first word is built from the live inputs in the same cycle
            // they are captured, so it matches the snapshot used for the rest.
            hours_d   = i_hours;
            minutes_d = i_minutes;
            seconds_d = i_seconds;
            dig_d     = '0;
            word_d    = frame_word(3'd0, i_hours, i_minutes, i_seconds);
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            state_d   = ST_SHIFT;
         end

         ST_SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling serial clock: present the next bit while low.
                  sclk_d    = 1'b0;
                  word_d    = {word_q[14:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     state_d = ST_LOAD;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         ST_LOAD: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         ST_GAP: begin
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            if (!init_done_q) begin
               if (idx_q == INIT_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = i_en ? ST_SNAP : ST_STALL;
               end else begin
                  idx_d = idx_q + 3'd1;
                  if (i_en) begin
                     word_d  = init_word(idx_q + 3'd1);
                     state_d = ST_SHIFT;
                  end else begin
                     state_d = ST_STALL;
                  end
               end
            end else if (dig_q == DIG_LAST) begin
               state_d = i_en ? ST_SNAP : ST_STALL;
            end else begin
               dig_d = dig_q + 3'd1;
               if (i_en) begin
                  word_d  = frame_word(dig_q + 3'd1, hours_q, minutes_q, seconds_q);
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end

         ST_STALL: begin
            // An interrupted init list resumes where it left off; an
            // interrupted frame is dropped and a fresh one starts at SNAP.
            if (i_en) begin
               if (!init_done_q) begin
                  word_d    = init_word(idx_q);
                  bit_cnt_d = '0;
                  div_cnt_d = '0;
                  sclk_d    = 1'b0;
                  state_d   = ST_SHIFT;
               end else begin
                  state_d = ST_SNAP;
               end
            end
         end

         default: state_d = ST_INIT;
      endcase
   end

   // Outputs decode registered state only, so reset clears them at once.
   assign o_serial_dout = (state_q == ST_SHIFT) & word_q[15];
   assign o_serial_clk  = (state_q == ST_SHIFT) & sclk_q;
   assign o_serial_load = (state_q == ST_LOAD);
   assign o_init_done   = init_done_q | ((state_q == ST_GAP) && (idx_q == INIT_LAST));
   assign o_frame_stb   = (state_q == ST_GAP) && init_done_q && (dig_q == DIG_LAST);

endmodule

// File: tb/tb_max7219_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_max7219_display_ctrl
//
// Drives random BCD times, predicts the MAX7219 register writes from the
// display rules, and checks them against words captured by a serial receiver.
// -----------------------------------------------------------------------------
module tb_max7219_display_ctrl;

   localparam int CLK_DIV  = 2;
   localparam int WORD_CYC = 33 * CLK_DIV + 1;
   localparam int STB_WAIT = 2000;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_en;
   logic [7:0] i_hours;
   logic [7:0] i_minutes;
   logic [7:0] i_seconds;
   logic       o_serial_dout;
   logic       o_serial_load;
   logic       o_serial_clk;
   logic       o_init_done;
   logic       o_frame_stb;

   max7219_display_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .INTENSITY  (4'hA),
      .SCAN_LIMIT (3'h7)
   ) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_en          (i_en),
      .i_hours       (i_hours),
      .i_minutes     (i_minutes),
      .i_seconds     (i_seconds),
      .o_serial_dout (o_serial_dout),
      .o_serial_load (o_serial_load),
      .o_serial_clk  (o_serial_clk),
      .o_init_done   (o_init_done),
      .o_frame_stb   (o_frame_stb)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] seg_model(input logic [3:0] n);
      case (n)
         4'd0: return 8'h7E;
         4'd1: return 8'h30;
         4'd2: return 8'h6D;
         4'd3: return 8'h79;
         4'd4: return 8'h33;
         4'd5: return 8'h5B;
         4'd6: return 8'h5F;
         4'd7: return 8'h70;
         4'd8: return 8'h7F;
         4'd9: return 8'h7B;
         default: return 8'h00;
      endcase
   endfunction

   task automatic push_init();
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h0900);
      exp_q.push_back(16'h0A0A);
      exp_q.push_back(16'h0B07);
      exp_q.push_back(16'h0C01);
   endtask

   task automatic push_frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      logic [3:0] digits[8];
      logic [7:0] data;
      digits = '{h[7:4], h[3:0], m[7:4], m[3:0], s[7:4], s[3:0], 4'hF, 4'hF};
      for (int i = 0; i < 8; i++) begin
         data = (i < 6) ? seg_model(digits[i]) : 8'h00;
         exp_q.push_back({4'h0, 4'(i + 1), data});
      end
   endtask

   function automatic logic [3:0] rand_nib(input int max);
      if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
      return 4'($urandom_range(0, max));
   endfunction

   task automatic randomize_time();
      i_hours   = {rand_nib(2), rand_nib(9)};
      i_minutes = {rand_nib(5), rand_nib(9)};
      i_seconds = {rand_nib(5), rand_nib(9)};
   endtask

   // ---------------- driver helpers ----------------
   task automatic wait_stb();
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_frame_stb && n < STB_WAIT);
      if (!o_frame_stb) begin
         checks++;
         errors++;
         $display("FAIL frame_stb_timeout: got none expected pulse within %0d cycles", STB_WAIT);
      end
   endtask

   task automatic check_idle(input int n, input logic done);
      repeat (n) begin
         @(negedge i_clk);
         check("idle_outputs",
               {27'd0, o_serial_dout, o_serial_load, o_serial_clk, o_frame_stb, o_init_done},
               {31'd0, done});
      end
   endtask

   // ---------------- monitor: MAX7219 receiver ----------------
   logic [15:0] rx_sr      = '0;
   int          rx_cnt     = 0;
   logic        prev_sclk  = 1'b0;
   logic        prev_load  = 1'b0;
   logic        prev_stb   = 1'b0;
   logic        have_prev  = 1'b0;
   logic [3:0]  last_addr  = '0;
   int          last_cyc   = 0;
   int          loads      = 0;

   function automatic int spacing(input logic [3:0] pa, input logic [3:0] ca);
      if (pa == 4'hF && ca == 4'h9) return WORD_CYC;
      if (pa >= 4'h9 && pa <= 4'hB && ca == pa + 4'd1) return WORD_CYC;
      if (pa >= 4'h1 && pa <= 4'h7 && ca == pa + 4'd1) return WORD_CYC;
      if (pa == 4'h8 && ca == 4'h1) return WORD_CYC + 1;
      return 0;
   endfunction

   always @(negedge i_clk) begin
      logic [3:0] addr;
      int         sp;
      if (!i_reset_n) begin
         rx_cnt    = 0;
         prev_sclk = 1'b0;
         prev_load = 1'b0;
         prev_stb  = 1'b0;
         have_prev = 1'b0;
      end else begin
         if (o_serial_clk && !prev_sclk) begin
            rx_sr = {rx_sr[14:0], o_serial_dout};
            rx_cnt++;
         end
         if (o_serial_load && !prev_load) begin
            addr = rx_sr[11:8];
            check("bits_per_word", rx_cnt, 16);
            rx_cnt = 0;
            check("init_done_at_load", {31'd0, o_init_done},
                  {31'd0, (addr >= 4'h1 && addr <= 4'h8)});
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL word_unexpected: got %04h expected no word", rx_sr);
            end else begin
               check("word", {16'd0, rx_sr}, {16'd0, exp_q.pop_front()});
            end
            if (have_prev) begin
               sp = spacing(last_addr, addr);
               if (sp != 0) check("load_spacing", cyc - last_cyc, sp);
            end
            have_prev = 1'b1;
            last_addr = addr;
            last_cyc  = cyc;
            loads++;
         end
         if (o_frame_stb) begin
            check("stb_pulse_width", {31'd0, prev_stb}, 32'd0);
            check("stb_after_addr8", {28'd0, last_addr}, 32'd8);
         end
         prev_sclk = o_serial_clk;
         prev_load = o_serial_load;
         prev_stb  = o_frame_stb;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] tail;
      i_reset_n = 1'b0;
      i_en      = 1'b1;
      i_hours   = 8'h10;
      i_minutes = 8'h59;
      i_seconds = 8'h00;
      repeat (3) @(negedge i_clk);
      check("reset_outputs",
            {27'd0, o_serial_dout, o_serial_load, o_serial_clk, o_frame_stb, o_init_done}, 32'd0);

      // Init sequence followed by the 10:59.00 frame.
      push_init();
      push_frame(i_hours, i_minutes, i_seconds);
      i_reset_n = 1'b1;
      wait_stb();
      check("init_done_after_init", {31'd0, o_init_done}, 32'd1);

      // Non-BCD minutes units blanks only that digit.
      i_minutes = 8'h5C;
      push_frame(i_hours, i_minutes, i_seconds);

      // Seconds change mid-frame must not leak into the current frame.
      wait_stb();
      i_minutes = 8'h42;
      i_seconds = 8'h00;
      push_frame(i_hours, i_minutes, i_seconds);
      repeat (1 + WORD_CYC + 30) @(negedge i_clk);
      i_seconds = 8'h01;
      wait_stb();
      push_frame(i_hours, i_minutes, i_seconds);

      // Random frames.
      for (int k = 0; k < 6; k++) begin
         wait_stb();
         randomize_time();
         push_frame(i_hours, i_minutes, i_seconds);
      end

      // Drop enable during the word to address 0x03.
      wait_stb();
      push_frame(i_hours, i_minutes, i_seconds);
      repeat (1 + 2 * WORD_CYC + 20) @(negedge i_clk);
      i_en = 1'b0;
      while (exp_q.size() > 0) begin
         tail = exp_q[exp_q.size() - 1];
         if (tail[11:8] > 4'h3) void'(exp_q.pop_back());
         else break;
      end
      repeat (2 * WORD_CYC) @(negedge i_clk);
      check("drained_before_stall", exp_q.size(), 0);
      check_idle(40, 1'b1);
      randomize_time();
      i_en = 1'b1;
      push_frame(i_hours, i_minutes, i_seconds);

      wait_stb();
      randomize_time();
      push_frame(i_hours, i_minutes, i_seconds);

      // Asynchronous reset around the 8th bit of the first word.
      repeat (1 + 7 * 2 * CLK_DIV + 2) @(negedge i_clk);
      #1 i_reset_n = 1'b0;
      #1 check("async_reset_outputs",
               {27'd0, o_serial_dout, o_serial_load, o_serial_clk, o_frame_stb, o_init_done}, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge i_clk);
      push_init();
      push_frame(i_hours, i_minutes, i_seconds);
      i_reset_n = 1'b1;

      // Park after this frame.
      wait_stb();
      i_en = 1'b0;
      repeat (3 * WORD_CYC) @(negedge i_clk);
      check("drained_at_end", exp_q.size(), 0);
      check_idle(20, 1'b1);

      // Enable low at reset release: no words at all.
      i_reset_n = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      check_idle(2 * WORD_CYC, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
